// File: rtl/keypad_scan_fifo_if.sv
// Key event stream between the keypad scanner (master) and its consumer (slave).
// Each event carries a key code and a press/release flag.
interface keypad_scan_fifo_if #(
   parameter int CODE_W = 4
);
   logic              evt_valid;
   logic              evt_ready;
   logic [CODE_W-1:0] evt_code;
   logic              evt_release;

   modport master (
      output evt_valid,
      output evt_code,
      output evt_release,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_code,
      input  evt_release,
      output evt_ready
   );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: row drive, synchronised column sampling, per-key frame
// debounce, and a small press/release event FIFO behind a valid/ready handshake.
module keypad_scan_fifo #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int SETTLE     = 500,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [COLS-1:0]     col_n,
   output logic [ROWS-1:0]     row_n,
   keypad_scan_fifo_if.master  evt,
   output logic                key_any,
   output logic                overflow,
   input  logic                ovf_clr
);
   localparam int NKEYS  = ROWS * COLS;
   localparam int CODE_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
   localparam int DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int NW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int PW     = $clog2(FIFO_DEPTH);

   localparam logic [DW-1:0] D_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] D_SETTLE = DW'(SETTLE);
   localparam logic [DW-1:0] D_P0     = DW'(SETTLE + 1);
   localparam logic [DW-1:0] D_PN     = DW'(SETTLE + COLS);
   localparam logic [RW-1:0] R_LAST   = RW'(ROWS - 1);
   localparam logic [NW-1:0] CNT_MAX  = NW'(DEBOUNCE - 1);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

   logic [DW-1:0]     dwell;
   logic [RW-1:0]     row;
   logic [RW-1:0]     row_nxt;
   logic [COLS-1:0]   sync1;
   logic [COLS-1:0]   sync2;
   logic [COLS-1:0]   samp;

   logic [NKEYS-1:0]  kstate;
   logic [NW-1:0]     kcnt [NKEYS];

   logic              proc_en;
   logic [CW-1:0]     pcol;
   logic [CODE_W-1:0] pkey;
   logic              raw;
   logic              flip;

   logic [CODE_W:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     rd_nxt;
   logic [PW:0]       count;
   logic [PW:0]       count_nxt;
   logic              full;
   logic              pop;
   logic              do_push;
   logic              drop;
   logic [CODE_W:0]   wdata;
   logic [CODE_W:0]   head_nxt;

   assign row_nxt = (dwell == D_LAST) ? ((row == R_LAST) ? '0 : row + 1'b1) : row;

   // Row drive and column sampling
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell <= '0;
         row   <= '0;
         row_n <= '1;
         sync1 <= '1;
         sync2 <= '1;
         samp  <= '1;
      end else begin
         sync1 <= col_n;
         sync2 <= sync1;
         if (dwell == D_SETTLE)
            samp <= sync2;
         dwell <= (dwell == D_LAST) ? '0 : dwell + 1'b1;
         row   <= row_nxt;
         row_n <= ~(ROWS'(1) << row_nxt);
      end
   end

   // One key of the current row is debounced per clock after the sample point
   always_comb begin
      proc_en = (dwell >= D_P0) && (dwell <= D_PN);
      pcol    = CW'(dwell - D_P0);
      pkey    = CODE_W'(int'(row) * COLS + int'(pcol));
      raw     = ~samp[pcol];
      flip    = proc_en && (raw != kstate[pkey]) && (kcnt[pkey] == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kstate  <= '0;
         key_any <= 1'b0;
         for (int i = 0; i < NKEYS; i++)
            kcnt[i] <= '0;
      end else begin
         key_any <= |kstate;
         if (proc_en) begin
            if (raw == kstate[pkey]) begin
               kcnt[pkey] <= '0;
            end else if (kcnt[pkey] == CNT_MAX) begin
               kstate[pkey] <= raw;
               kcnt[pkey]   <= '0;
            end else begin
               kcnt[pkey] <= kcnt[pkey] + 1'b1;
            end
         end
      end
   end

   // Event queue; the head is re-registered each cycle, bypassing a push into an emptied slot
   always_comb begin
      full      = (count == FULL_CNT);
      pop       = evt.evt_valid && evt.evt_ready;
      do_push   = flip && (!full || pop);
      drop      = flip && full && !pop;
      wdata     = {~raw, pkey};
      rd_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;
      count_nxt = count + (PW+1)'(do_push) - (PW+1)'(pop);
      head_nxt  = (do_push && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];
      if (count_nxt == '0)
         head_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         evt.evt_valid   <= 1'b0;
         evt.evt_code    <= '0;
         evt.evt_release <= 1'b0;
         overflow        <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr          <= rd_nxt;
         count           <= count_nxt;
         evt.evt_valid   <= (count_nxt != '0);
         evt.evt_code    <= head_nxt[CODE_W-1:0];
         evt.evt_release <= head_nxt[CODE_W];
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: 4x4 keypad model driven from row_n,
// frame-aligned stimulus and hand-computed event timing (frame = 32 clocks).
module tb_keypad_scan_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic        key_any;
   logic        overflow;
   logic        ovf_clr;
   logic [15:0] keys;

   int tests = 0;
   int fails = 0;

   keypad_scan_fifo_if #(.CODE_W(4)) evt_if ();

   keypad_scan_fifo #(
      .ROWS(4), .COLS(4), .SCAN_DIV(8), .SETTLE(3), .DEBOUNCE(3), .FIFO_DEPTH(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .col_n    (col_n),
      .row_n    (row_n),
      .evt      (evt_if),
      .key_any  (key_any),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   // A pressed key pulls its column low while its row is driven
   always_comb begin
      col_n = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_n[r] && keys[r*4+c])
               col_n[c] = 1'b0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame_start();
      logic [3:0] prev;
      prev = row_n;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (row_n == 4'hE && prev == 4'h7) return;
         prev = row_n;
      end
      tests++; fails++;
      $display("FAIL frame_sync: row_n=%h, frame start not seen in 100 clk", row_n);
   endtask

   // Runs ncyc clocks, recording accepted events; cycle 0 is the current cycle
   task automatic run_monitor(input int ncyc, output int n, output int first,
                              output int code, output int rel);
      n = 0; first = -1; code = -1; rel = -1;
      for (int i = 0; i < ncyc; i++) begin
         if (evt_if.evt_valid && evt_if.evt_ready) begin
            n++;
            if (n == 1) begin
               first = i;
               code  = int'(evt_if.evt_code);
               rel   = int'(evt_if.evt_release);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; keys = '0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
      tick(); tick(); tick();
      tests++;
      if ({row_n, evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, key_any, overflow} !== 12'hF00) begin
         fails++;
         $display("FAIL reset_outputs: row_n=%h valid=%b code=%0d rel=%b any=%b ovf=%b, required F,0,0,0,0,0",
                  row_n, evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, key_any, overflow);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (row_n !== 4'hE) begin
         fails++;
         $display("FAIL first_row: row_n=%h, required e", row_n);
      end
   endtask

   task automatic test_idle_scan();
      int row_err = 0;
      int out_err = 0;
      logic [3:0] e;
      wait_frame_start();
      for (int i = 0; i < 200; i++) begin
         e = ~(4'b0001 << ((i / 8) % 4));
         if (row_n !== e) row_err++;
         if (evt_if.evt_valid !== 1'b0 || key_any !== 1'b0) out_err++;
         tick();
      end
      tests++;
      if (row_err != 0) begin
         fails++;
         $display("FAIL idle_row_seq: %0d cycles with wrong row_n, required 0", row_err);
      end
      tests++;
      if (out_err != 0) begin
         fails++;
         $display("FAIL idle_quiet: %0d cycles with valid/key_any set, required 0", out_err);
      end
   endtask

   task automatic test_press();
      int n, first, code, rel;
      evt_if.evt_ready = 1'b1;
      wait_frame_start();
      keys = 16'h0200;
      run_monitor(128, n, first, code, rel);
      tests++;
      if (n != 1 || first != 86 || code != 9 || rel != 0) begin
         fails++;
         $display("FAIL press_k9: n=%0d at=%0d code=%0d rel=%0d, required 1,86,9,0", n, first, code, rel);
      end
      tests++;
      if (key_any !== 1'b1) begin
         fails++;
         $display("FAIL press_key_any: key_any=%b, required 1", key_any);
      end
   endtask

   task automatic test_release();
      int n, first, code, rel, n2, f2, c2, r2;
      wait_frame_start();
      keys = 16'h0000;
      run_monitor(128, n, first, code, rel);
      tests++;
      if (n != 1 || first != 86 || code != 9 || rel != 1) begin
         fails++;
         $display("FAIL release_k9: n=%0d at=%0d code=%0d rel=%0d, required 1,86,9,1", n, first, code, rel);
      end
      tests++;
      if (key_any !== 1'b0) begin
         fails++;
         $display("FAIL release_key_any: key_any=%b, required 0", key_any);
      end
      wait_frame_start();
      keys = 16'h0200;
      run_monitor(32, n, first, code, rel);
      keys = 16'h0000;
      run_monitor(96, n2, f2, c2, r2);
      tests++;
      if (n + n2 != 0 || key_any !== 1'b0) begin
         fails++;
         $display("FAIL glitch: events=%0d key_any=%b, required 0,0", n + n2, key_any);
      end
   endtask

   task automatic test_overflow();
      int n, first, code, rel;
      int exp_code [4] = '{0, 5, 10, 15};
      evt_if.evt_ready = 1'b0;
      wait_frame_start();
      keys = 16'h8421;
      run_monitor(128, n, first, code, rel);
      tests++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 4'd0 || evt_if.evt_release !== 1'b0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL queue4_head: valid=%b code=%0d rel=%b ovf=%b, required 1,0,0,0",
                  evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, overflow);
      end
      wait_frame_start();
      keys = 16'h8420;
      run_monitor(128, n, first, code, rel);
      tests++;
      if (overflow !== 1'b1 || evt_if.evt_code !== 4'd0 || evt_if.evt_release !== 1'b0) begin
         fails++;
         $display("FAIL drop_ovf: ovf=%b head code=%0d rel=%b, required 1,0,0",
                  overflow, evt_if.evt_code, evt_if.evt_release);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clr: overflow=%b, required 0", overflow);
      end
      evt_if.evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (evt_if.evt_valid !== 1'b1 || int'(evt_if.evt_code) != exp_code[i] || evt_if.evt_release !== 1'b0) begin
            fails++;
            $display("FAIL drain_%0d: valid=%b code=%0d rel=%b, required 1,%0d,0",
                     i, evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, exp_code[i]);
         end
         tick();
      end
      tests++;
      if (evt_if.evt_valid !== 1'b0) begin
         fails++;
         $display("FAIL drain_empty: valid=%b, required 0", evt_if.evt_valid);
      end
   endtask

   task automatic test_back_to_back();
      int exp_code [4] = '{1, 5, 10, 15};
      logic exp_rel [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      evt_if.evt_ready = 1'b0;
      wait_frame_start();
      keys = 16'h0003;
      for (int i = 0; i < 95; i++) tick();
      tests++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 4'd0 || evt_if.evt_release !== 1'b0) begin
         fails++;
         $display("FAIL full_head: valid=%b code=%0d rel=%b, required 1,0,0",
                  evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release);
      end
      evt_if.evt_ready = 1'b1;
      tick();
      evt_if.evt_ready = 1'b0;
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL full_push_pop_ovf: overflow=%b, required 0", overflow);
      end
      evt_if.evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (evt_if.evt_valid !== 1'b1 || int'(evt_if.evt_code) != exp_code[i] || evt_if.evt_release !== exp_rel[i]) begin
            fails++;
            $display("FAIL b2b_%0d: valid=%b code=%0d rel=%b, required 1,%0d,%b",
                     i, evt_if.evt_valid, evt_if.evt_code, evt_if.evt_release, exp_code[i], exp_rel[i]);
         end
         tick();
      end
      tests++;
      if (evt_if.evt_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_empty: valid=%b, required 0", evt_if.evt_valid);
      end
   endtask

   task automatic test_reset_mid();
      int n, first, code, rel;
      evt_if.evt_ready = 1'b0;
      wait_frame_start();
      keys = 16'h0200;
      for (int i = 0; i < 80; i++) tick();
      tests++;
      if (evt_if.evt_valid !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset_queue: valid=%b, required 1", evt_if.evt_valid);
      end
      rst = 1'b1;
      tick();
      tests++;
      if (evt_if.evt_valid !== 1'b0 || row_n !== 4'hF || key_any !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: valid=%b row_n=%h any=%b, required 0,f,0", evt_if.evt_valid, row_n, key_any);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (row_n !== 4'hE) begin
         fails++;
         $display("FAIL mid_reset_row: row_n=%h, required e", row_n);
      end
      evt_if.evt_ready = 1'b1;
      run_monitor(200, n, first, code, rel);
      tests++;
      if (n != 1 || code != 9 || rel != 0) begin
         fails++;
         $display("FAIL rereport_k9: n=%0d code=%0d rel=%0d, required 1,9,0", n, code, rel);
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_press();
      test_release();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised matrix-keypad scanner, successor to the fixed 4x4 scanner. Drives one row low at a time and samples the active-low columns through a 2-flop synchroniser. Each key is debounced independently over whole scan frames, and both press and release events are emitted. Events are queued in a small FIFO behind a valid/ready handshake for the control FSM, replacing the old single-register keyOut/keyValid pair.

Parameters:
ROWS, 4, number of row drive lines (>=1)
COLS, 4, number of column sense lines (>=1)
SCAN_DIV, 1000, clocks each row stays driven (dwell); must be >= SETTLE+COLS+1
SETTLE, 500, dwell cycle index at which the synchronised columns are latched
DEBOUNCE, 4, consecutive differing frame samples needed to flip a key's state (>=1)
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)
CODE_W, $clog2(ROWS*COLS) (min 1), derived key-code width

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
col_n  in  COLS  column sense, active-low, asynchronous to clk
row_n  out  ROWS  row drive, active-low, registered, exactly one bit low outside reset
evt_valid  out  1  FIFO non-empty; head event presented
evt_ready  in  1  consumer accepts head event
evt_code  out  CODE_W  head key code = row*COLS + col
evt_release  out  1  head event type: 0 press, 1 release
key_any  out  1  at least one key in debounced-pressed state
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow (one-cycle pulse)

Behaviour:
- Reset (rst=1 at an edge): row_n=all ones; row index=0; dwell counter=0; synchroniser=all ones; all key states released; all debounce counters 0; FIFO empty; evt_valid=0, evt_code=0, evt_release=0, key_any=0, overflow=0. Reset mid-scan or mid-FIFO discards everything and emits no release events.
- Scan: on the first edge after reset, row_n = ~(1<<0). Dwell counter d runs 0..SCAN_DIV-1. At d=SCAN_DIV-1, row index advances (ROWS-1 wraps to 0) and row_n updates on the same edge. Frame = ROWS*SCAN_DIV clocks.
- Sample: at d=SETTLE, latch the synchronised col_n into samp. Raw pressed(c) = ~samp[c].
- Process: at d=SETTLE+1+c for c=0..COLS-1, handle key k=row*COLS+c, one key per clock, at most one FIFO push per clock.
  - raw==state[k]: cnt[k]<=0.
  - raw!=state[k] and cnt[k]<DEBOUNCE-1: cnt[k]++.
  - raw!=state[k] and cnt[k]==DEBOUNCE-1: state[k] flips, cnt[k]<=0, push {release=~raw, code=k}.
  - DEBOUNCE=1 flips on the first differing sample.
- Event order is ascending column within a row, then ascending row. Press-to-event latency is DEBOUNCE samples of that key's row, plus the synchroniser, plus the processing slot.
- FIFO:
  - evt_valid = not empty; evt_code and evt_release show the head entry, registered. Data holds stable while valid && !ready.
  - Pop on evt_valid && evt_ready.
  - When full, push and pop in the same cycle both succeed (occupancy unchanged).
  - When full with no pop, the push is dropped, overflow<=1, and state[k] still flips, so no duplicate event is generated later.
  - When empty, push and pop cannot coincide (valid=0).
- overflow: if ovf_clr and a drop occur on the same edge, set wins. Otherwise ovf_clr clears it.
- key_any is the registered OR of all state[k]; it updates the cycle after a flip.
- Multi-key ghosting is not resolved: keys are reported as sampled.

Test Plan:
Bench params ROWS=4, COLS=4, SCAN_DIV=8, SETTLE=3, DEBOUNCE=3, FIFO_DEPTH=4 (frame=32 clk).
1. Reset, then idle with col_n=4'hF for 200 clk -> row_n cycles E,D,B,7 (hex), 8 clk each; evt_valid=0, key_any=0.
2. Hold key row 2/col 1 (col_n[1]=0 only while row_n=4'hB) for 4 frames with evt_ready=1 -> exactly one event, code=9, release=0, in the 3rd frame at d=5 of row 2 (+1 clk registered); key_any=1.
3. Release after test 2 -> one event code=9, release=1, after 3 frames; key_any=0. A 1-frame glitch (press then release next frame) -> no event.
4. Press keys 0, 5, 10, 15 simultaneously with evt_ready=0 -> 4 press events queued in order 0,5,10,15. A 5th event (release of 0) -> dropped, overflow=1. Pulse ovf_clr -> overflow=0. Raise ready -> 4 pops, in order, one per clk.
5. FIFO full, evt_ready=1 on the same clk as a push -> no drop, overflow stays 0, and the new event appears last.
6. Assert rst mid-frame with 2 events queued and key 9 held -> next cycle evt_valid=0, row_n=F, then E; key 9 is re-reported as a press after 3 frames.
